// File: rtl/grad_accum_bank.sv
// grad_accum_bank
// Bank of NCH signed accumulators. Each accumulate request latches a gradient
// vector and adds -LR*grad[i] to accumulator i. One channel is updated per
// cycle through a single shared multiplier. Each accumulator is presented as a
// saturated fixed-point delta.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   clr        in   step-start clear: zero accumulators and sat flags, abort run
//   acc_start  in   accumulate request, sampled only while idle
//   grad_in    in   NCH x DW signed gradients, channel i at [i*DW +: DW]
//   busy       out  high while a run is in progress (state != IDLE)
//   done       out  one-cycle pulse after the last channel is updated
//   sat_flag   out  sticky per-channel delta-saturation flag
//   delta_out  out  NCH x DW per-channel delta, channel i at [i*DW +: DW]
module grad_accum_bank #(
    parameter int unsigned          NCH  = 4,
    parameter int unsigned          DW   = 16,
    parameter int unsigned          FRAC = 10,
    parameter int unsigned          ACCW = 32,
    parameter logic signed [DW-1:0] LR   = 16'sd102
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_start,
    input  logic [NCH*DW-1:0] grad_in,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    sat_flag,
    output logic [NCH*DW-1:0] delta_out
);

    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    // Number of accumulator bits at and above the delta sign bit.
    localparam int unsigned HIW  = ACCW - FRAC - DW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    typedef logic signed [ACCW-1:0] acc_t;
    typedef logic signed [DW-1:0]   grad_t;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] ch_idx_q, ch_idx_d;
    logic [NCH-1:0]  sat_q, sat_d;
    acc_t            acc_q  [NCH];
    acc_t            acc_d  [NCH];
    grad_t           grad_q [NCH];
    grad_t           grad_d [NCH];

    grad_t                  g_sel_c;
    logic signed [2*DW-1:0] prod_c;
    logic signed [ACCW:0]   diff_c;
    acc_t                   upd_c;
    logic [DW:0]            q_clamp_c [NCH];
    logic [DW:0]            d_clamp_c [NCH];

    // Slice acc[FRAC+DW-1:FRAC]; clamp to the signed DW range when the bits
    // above the delta sign bit are not a pure sign extension. MSB = clamped.
    function automatic logic [DW:0] clamp_delta(input acc_t a);
        logic [HIW-1:0] hi;
        hi = a[ACCW-1:FRAC+DW-1];
        if ((hi == '0) || (hi == '1)) begin
            clamp_delta = {1'b0, a[FRAC+DW-1:FRAC]};
        end else if (a[ACCW-1]) begin
            clamp_delta = {2'b11, {(DW-1){1'b0}}};
        end else begin
            clamp_delta = {2'b10, {(DW-1){1'b1}}};
        end
    endfunction

    // Shared multiply/subtract for the channel selected by ch_idx, with
    // saturation at the signed accumulator bounds.
    always_comb begin
        g_sel_c = grad_q[ch_idx_q];
        prod_c  = g_sel_c * LR;
        diff_c  = (ACCW+1)'(acc_q[ch_idx_q]) - (ACCW+1)'(prod_c);
        if (diff_c[ACCW] != diff_c[ACCW-1]) begin
            upd_c = diff_c[ACCW] ? ACC_MIN : ACC_MAX;
        end else begin
            upd_c = diff_c[ACCW-1:0];
        end
    end

    // Next-state logic; clr overrides whatever the FSM would do.
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        sat_d    = sat_q;
        for (int i = 0; i < NCH; i++) begin
            acc_d[i]     = acc_q[i];
            grad_d[i]    = grad_q[i];
            d_clamp_c[i] = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (acc_start) begin
                    for (int i = 0; i < NCH; i++) begin
                        grad_d[i] = grad_in[i*DW +: DW];
                    end
                    ch_idx_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[ch_idx_q] = upd_c;
                if (ch_idx_q == IDXW'(NCH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ch_idx_d = ch_idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flag is raised on the same edge that makes the delta clamp, so the
        // flag and the clamped delta become visible together.
        for (int i = 0; i < NCH; i++) begin
            d_clamp_c[i] = clamp_delta(acc_d[i]);
            if (d_clamp_c[i][DW]) begin
                sat_d[i] = 1'b1;
            end
        end

        if (clr) begin
            state_d  = ST_IDLE;
            ch_idx_d = '0;
            sat_d    = '0;
            for (int i = 0; i < NCH; i++) begin
                acc_d[i] = '0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            sat_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                grad_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            sat_q    <= sat_d;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= acc_d[i];
                grad_q[i] <= grad_d[i];
            end
        end
    end

    // Delta outputs decoded from the accumulator registers.
    always_comb begin
        delta_out = '0;
        for (int i = 0; i < NCH; i++) begin
            q_clamp_c[i]          = clamp_delta(acc_q[i]);
            delta_out[i*DW +: DW] = q_clamp_c[i][DW-1:0];
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_grad_accum_bank.sv
// Self-checking bench for grad_accum_bank. A bench-side model computes the
// expected delta/sat vector when each run is launched and queues it; the entry
// is popped and compared when the DUT pulses done.
module tb_grad_accum_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned VW  = NCH * DW;

    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          acc_start;
    logic [VW-1:0] grad_in;
    logic          busy;
    logic          done;
    logic [NCH-1:0] sat_flag;
    logic [VW-1:0] delta_out;

    typedef struct {
        logic [VW-1:0]  delta;
        logic [NCH-1:0] sat;
    } exp_t;

    exp_t           sb_q[$];
    longint         macc [NCH];
    logic [NCH-1:0] msat;
    int             n_cmp = 0;
    int             n_bad = 0;

    grad_accum_bank dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .acc_start (acc_start),
        .grad_in   (grad_in),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag),
        .delta_out (delta_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) macc[i] = 0;
        msat = '0;
    endfunction

    // Reference arithmetic in 64-bit integers: acc -= 102*g, clamp to int32,
    // delta = acc >>> 10 clamped to int16.
    function automatic exp_t model_run(input logic [VW-1:0] g);
        exp_t   e;
        longint p;
        longint v;
        logic [DW-1:0] gl;
        for (int i = 0; i < NCH; i++) begin
            gl = g[i*DW +: DW];
            p  = longint'($signed(gl)) * 64'sd102;
            macc[i] = macc[i] - p;
            if (macc[i] > AMAX) macc[i] = AMAX;
            if (macc[i] < AMIN) macc[i] = AMIN;
        end
        for (int i = 0; i < NCH; i++) begin
            v = macc[i] >>> 10;
            if (v > 64'sd32767) begin
                e.delta[i*DW +: DW] = 16'h7FFF;
                msat[i] = 1'b1;
            end else if (v < -64'sd32768) begin
                e.delta[i*DW +: DW] = 16'h8000;
                msat[i] = 1'b1;
            end else begin
                e.delta[i*DW +: DW] = v[15:0];
            end
        end
        e.sat = msat;
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // sampling edge T.
    task automatic start_run(input logic [VW-1:0] g);
        acc_start = 1'b1;
        grad_in   = g;
        sb_q.push_back(model_run(g));
        @(negedge clk);
        acc_start = 1'b0;
        grad_in   = {$urandom, $urandom};
    endtask

    // Bounded wait for done, sampled on negedges; cyc counts negedges after T.
    task automatic wait_done(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; acc_start = 1'b0; grad_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (delta_out !== '0) begin n_bad++; $display("FAIL reset_delta got=%h exp=0", delta_out); end
        n_cmp++; if (sat_flag !== '0) begin n_bad++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    endtask

    task automatic test_basic();
        bit seen; int cyc; exp_t e;
        start_run({16'h0800, 16'h0000, 16'hFE00, 16'h0200});
        wait_done(seen, cyc);
        n_cmp++; if (!seen || cyc != NCH) begin n_bad++; $display("FAIL basic_done seen=%0b cyc=%0d exp_cyc=%0d", seen, cyc, NCH); end
        e = sb_q.pop_front();
        n_cmp++; if (delta_out !== e.delta) begin n_bad++; $display("FAIL basic_sb got=%h exp=%h", delta_out, e.delta); end
        n_cmp++; if (delta_out !== {16'hFF34, 16'h0000, 16'h0033, 16'hFFCD}) begin
            n_bad++; $display("FAIL basic_const got=%h exp=ff3400000033ffcd", delta_out); end
        n_cmp++; if (sat_flag !== e.sat) begin n_bad++; $display("FAIL basic_sat got=%b exp=%b", sat_flag, e.sat); end
    endtask

    task automatic test_second_run_clr();
        bit seen; int cyc; exp_t e;
        @(negedge clk);
        start_run({16'h0800, 16'h0000, 16'hFE00, 16'h0800});
        wait_done(seen, cyc);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL second_done timeout got=0 exp=1"); end
        e = sb_q.pop_front();
        n_cmp++; if (delta_out !== e.delta) begin n_bad++; $display("FAIL second_sb got=%h exp=%h", delta_out, e.delta); end
        n_cmp++; if (delta_out[0 +: DW] !== 16'hFF01) begin n_bad++; $display("FAIL second_ch0 got=%h exp=ff01", delta_out[0 +: DW]); end
        pulse_clr();
        n_cmp++; if (delta_out !== '0) begin n_bad++; $display("FAIL clr_delta got=%h exp=0", delta_out); end
        n_cmp++; if (sat_flag !== '0) begin n_bad++; $display("FAIL clr_sat got=%b exp=0", sat_flag); end
    endtask

    // busy/done cycle profile, with a stray acc_start sampled while running.
    task automatic test_timing();
        int extra; exp_t e;
        @(negedge clk);
        start_run({16'h0100, 16'hFF00, 16'h0040, 16'h0300});
        for (int c = 0; c <= NCH + 1; c++) begin
            n_cmp++; if (busy !== (c <= NCH)) begin n_bad++; $display("FAIL timing_busy c=%0d got=%b exp=%b", c, busy, (c <= NCH)); end
            n_cmp++; if (done !== (c == NCH)) begin n_bad++; $display("FAIL timing_done c=%0d got=%b exp=%b", c, done, (c == NCH)); end
            if (c == 1) begin acc_start = 1'b1; grad_in = {4{16'h1234}}; end
            if (c == 2) acc_start = 1'b0;
            if (c == NCH) e = sb_q.pop_front();
            if (c == NCH) begin
                n_cmp++; if (delta_out !== e.delta) begin n_bad++; $display("FAIL timing_sb got=%h exp=%h", delta_out, e.delta); end
            end
            @(negedge clk);
        end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy || done) extra++;
            @(negedge clk);
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL timing_stray_run got=%0d busy_cycles exp=0", extra); end
        n_cmp++; if (delta_out !== e.delta) begin n_bad++; $display("FAIL timing_unchanged got=%h exp=%h", delta_out, e.delta); end
    endtask

    task automatic test_back_to_back();
        bit seen; int cyc; exp_t e;
        start_run({16'h0010, 16'h0020, 16'hFFF0, 16'h0400});
        wait_done(seen, cyc);
        e = sb_q.pop_front();
        n_cmp++; if (!seen || delta_out !== e.delta) begin n_bad++; $display("FAIL b2b_first seen=%0b got=%h exp=%h", seen, delta_out, e.delta); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
        start_run({16'hFC00, 16'h0000, 16'h0001, 16'hF800});
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_done(seen, cyc);
        e = sb_q.pop_front();
        n_cmp++; if (!seen || delta_out !== e.delta) begin n_bad++; $display("FAIL b2b_second seen=%0b got=%h exp=%h", seen, delta_out, e.delta); end
        n_cmp++; if (sat_flag !== e.sat) begin n_bad++; $display("FAIL b2b_sat got=%b exp=%b", sat_flag, e.sat); end
    endtask

    // Output clamp at +3264/run, stickiness, then accumulator saturation.
    task automatic test_saturation();
        bit seen; int cyc; exp_t e;
        logic [VW-1:0] gneg;
        logic [VW-1:0] gpos;
        gneg = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
        gpos = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        pulse_clr();
        for (int r = 1; r <= 11; r++) begin
            start_run(gneg);
            wait_done(seen, cyc);
            e = sb_q.pop_front();
            n_cmp++; if (!seen || delta_out !== e.delta || sat_flag !== e.sat) begin
                n_bad++; $display("FAIL sat_run%0d seen=%0b got=%h/%b exp=%h/%b", r, seen, delta_out, sat_flag, e.delta, e.sat); end
            if (r == 10) begin
                n_cmp++; if (delta_out[0 +: DW] !== 16'h7F80 || sat_flag[0] !== 1'b0) begin
                    n_bad++; $display("FAIL sat_10 got=%h/%b exp=7f80/0", delta_out[0 +: DW], sat_flag[0]); end
            end
            if (r == 11) begin
                n_cmp++; if (delta_out[0 +: DW] !== 16'h7FFF || sat_flag[0] !== 1'b1) begin
                    n_bad++; $display("FAIL sat_11 got=%h/%b exp=7fff/1", delta_out[0 +: DW], sat_flag[0]); end
            end
            @(negedge clk);
        end
        start_run(gpos);
        wait_done(seen, cyc);
        e = sb_q.pop_front();
        n_cmp++; if (delta_out[0 +: DW] !== 16'h7F80 || sat_flag[0] !== 1'b1) begin
            n_bad++; $display("FAIL sat_sticky got=%h/%b exp=7f80/1", delta_out[0 +: DW], sat_flag[0]); end
        @(negedge clk);
        for (int r = 0; r < 640; r++) begin
            start_run(gneg);
            wait_done(seen, cyc);
            e = sb_q.pop_front();
            n_cmp++; if (!seen || delta_out !== e.delta || sat_flag !== e.sat) begin
                n_bad++; $display("FAIL acc_sat_run%0d seen=%0b got=%h/%b exp=%h/%b", r, seen, delta_out, sat_flag, e.delta, e.sat); end
            @(negedge clk);
        end
        start_run(gpos);
        wait_done(seen, cyc);
        e = sb_q.pop_front();
        n_cmp++; if (delta_out !== e.delta || delta_out[0 +: DW] !== 16'h7FFF) begin
            n_bad++; $display("FAIL acc_nowrap got=%h exp=%h", delta_out, e.delta); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_run();
        start_run({16'h0200, 16'h0200, 16'h0200, 16'h0200});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_clear();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctl got=%b%b exp=00", busy, done); end
        n_cmp++; if (delta_out !== '0) begin n_bad++; $display("FAIL rst_mid_delta got=%h exp=0", delta_out); end
        n_cmp++; if (sat_flag !== '0) begin n_bad++; $display("FAIL rst_mid_sat got=%b exp=0", sat_flag); end
    endtask

    task automatic test_clr_mid_run();
        bit seen; int cyc; int extra; exp_t e;
        @(negedge clk);
        start_run({16'h0400, 16'hFC00, 16'h0200, 16'hFE00});
        wait_done(seen, cyc);
        e = sb_q.pop_front();
        n_cmp++; if (!seen || delta_out !== e.delta) begin n_bad++; $display("FAIL clrmid_setup seen=%0b got=%h exp=%h", seen, delta_out, e.delta); end
        @(negedge clk);
        start_run({16'h0400, 16'h0400, 16'h0400, 16'h0400});
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        sb_q.delete();
        model_clear();
        n_cmp++; if (busy !== 1'b0 || delta_out !== '0 || sat_flag !== '0) begin
            n_bad++; $display("FAIL clrmid_state busy=%b got=%h/%b exp=0/0", busy, delta_out, sat_flag); end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL clrmid_no_done got=%0d exp=0", extra); end
        clr = 1'b1; acc_start = 1'b1; grad_in = {4{16'h0800}};
        @(negedge clk);
        clr = 1'b0; acc_start = 1'b0;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL clr_start_dropped got=%0d exp=0", extra); end
        n_cmp++; if (delta_out !== '0) begin n_bad++; $display("FAIL clr_start_delta got=%h exp=0", delta_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_run_clr();
        test_timing();
        test_back_to_back();
        test_saturation();
        test_rst_mid_run();
        test_clr_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
